// File: rtl/licznik_rozkazow_stos_if.sv
// Decoder <-> program counter bus for licznik_rozkazow_stos.
// The stos_pc_blad error flag exists only when PC_STOS_BLAD_EN is defined.
interface licznik_rozkazow_stos_if #(
   parameter int unsigned PC_WIDTH  = 8,
   parameter int unsigned STOS_GLEB = 8
);
   localparam int unsigned CntW = $clog2(STOS_GLEB + 1);

   // Requests from the decoder
   logic                en;
   logic                ID_rst;
   logic                skok;
   logic [PC_WIDTH-1:0] adres_skok;
   logic                skok_pc;
   logic                push_pc;
   logic                pop_pc;
   logic                jest_przerwanie;

   // PC and stack status back to the decoder / program memory
   logic [PC_WIDTH-1:0] pc;
   logic                stos_pc_empty;
   logic                stos_pc_full;
   logic [CntW-1:0]     stos_pc_ile;
`ifdef PC_STOS_BLAD_EN
   logic                stos_pc_blad;
`endif

   // Decoder side
   modport master (
      output en, ID_rst, skok, adres_skok, skok_pc, push_pc, pop_pc, jest_przerwanie,
      input  pc, stos_pc_empty, stos_pc_full, stos_pc_ile
`ifdef PC_STOS_BLAD_EN
      , input stos_pc_blad
`endif
   );

   // Program counter side
   modport slave (
      input  en, ID_rst, skok, adres_skok, skok_pc, push_pc, pop_pc, jest_przerwanie,
      output pc, stos_pc_empty, stos_pc_full, stos_pc_ile
`ifdef PC_STOS_BLAD_EN
      , output stos_pc_blad
`endif
   );
endinterface

// File: rtl/licznik_rozkazow_stos.sv
// Program counter with integrated return-address stack.
// Optional sticky stack-error flag enabled by defining PC_STOS_BLAD_EN.
module licznik_rozkazow_stos #(
   parameter int unsigned         PC_WIDTH  = 8,
   parameter int unsigned         STOS_GLEB = 8,
   parameter logic [PC_WIDTH-1:0] RESET_VEC = '0
) (
   input logic                   clk,
   input logic                   rst,
   licznik_rozkazow_stos_if.slave bus
);
   localparam int unsigned CntW = $clog2(STOS_GLEB + 1);
   localparam int unsigned AW   = (STOS_GLEB > 1) ? $clog2(STOS_GLEB) : 1;

   logic [PC_WIDTH-1:0] r_pc;
   logic [CntW-1:0]     r_cnt;
   logic [PC_WIDTH-1:0] r_mem [STOS_GLEB];

   logic [PC_WIDTH-1:0] w_pc_d;
   logic [CntW-1:0]     w_cnt_d;
   logic                w_we;
   logic [PC_WIDTH-1:0] w_ret;
   logic [PC_WIDTH-1:0] w_top;
   logic [AW-1:0]       w_top_idx;
   logic [AW-1:0]       w_wr_idx;
   logic                w_empty;
   logic                w_full;
   logic                w_illegal;

   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == CntW'(STOS_GLEB));
   assign w_illegal = bus.push_pc && bus.pop_pc;
   // Top index is garbage when empty; callers guard with w_empty
   assign w_top_idx = AW'(r_cnt - 1'b1);
   assign w_wr_idx  = AW'(r_cnt);
   assign w_top     = r_mem[w_top_idx];
   // An interrupted instruction did not execute, so it is its own return address
   assign w_ret     = bus.jest_przerwanie ? r_pc : r_pc + 1'b1;

   // Next PC / count / stack write for one enabled edge, in request priority order
   always_comb begin
      w_pc_d  = r_pc + 1'b1;
      w_cnt_d = r_cnt;
      w_we    = 1'b0;
      if (w_illegal) begin
         // push and pop together: no stack change, just advance
      end else if (bus.skok && bus.skok_pc) begin
         if (!w_empty) begin
            w_pc_d = w_top;
            if (bus.pop_pc) w_cnt_d = r_cnt - 1'b1;
         end
      end else begin
         if (bus.skok) w_pc_d = bus.adres_skok;
         if (bus.push_pc && !w_full) begin
            w_we    = 1'b1;
            w_cnt_d = r_cnt + 1'b1;
         end
         if (bus.pop_pc && !w_empty) w_cnt_d = r_cnt - 1'b1;
      end
   end

   // PC and entry count: async reset, soft reset beats stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc  <= RESET_VEC;
         r_cnt <= '0;
      end else if (bus.ID_rst) begin
         r_pc  <= RESET_VEC;
         r_cnt <= '0;
      end else if (bus.en) begin
         r_pc  <= w_pc_d;
         r_cnt <= w_cnt_d;
      end
   end

   // Stack storage is not reset; only entries below the count are ever read
   always_ff @(posedge clk) begin
      if (bus.en && !bus.ID_rst && w_we) r_mem[w_wr_idx] <= w_ret;
   end

   assign bus.pc            = r_pc;
   assign bus.stos_pc_empty = w_empty;
   assign bus.stos_pc_full  = w_full;
   assign bus.stos_pc_ile   = r_cnt;

`ifdef PC_STOS_BLAD_EN
   logic r_blad;
   logic w_blad_set;

   assign w_blad_set = w_illegal
                     || (bus.push_pc && w_full)
                     || (bus.pop_pc && w_empty)
                     || (bus.skok && bus.skok_pc && w_empty);

   // Sticky error flag, cleared only by a reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blad <= 1'b0;
      end else if (bus.ID_rst) begin
         r_blad <= 1'b0;
      end else if (bus.en && w_blad_set) begin
         r_blad <= 1'b1;
      end
   end

   assign bus.stos_pc_blad = r_blad;
`endif
endmodule

// File: tb/tb_licznik_rozkazow_stos.sv
// Directed table-driven bench for licznik_rozkazow_stos.
// Checks stos_pc_blad as well when PC_STOS_BLAD_EN is defined.
module tb_licznik_rozkazow_stos;
   logic clk = 1'b0;
   logic rst = 1'b1;

   licznik_rozkazow_stos_if #(.PC_WIDTH(8), .STOS_GLEB(8)) bus ();

   licznik_rozkazow_stos #(
      .PC_WIDTH (8),
      .STOS_GLEB(8),
      .RESET_VEC(8'h00)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       id_rst;
      logic       skok;
      logic [7:0] adres;
      logic       skok_pc;
      logic       push;
      logic       pop;
      logic       przer;
      logic [7:0] exp_pc;
      logic [3:0] exp_cnt;
      logic       exp_blad;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(logic en, logic id_rst, logic skok, logic [7:0] adres,
                               logic skok_pc, logic push, logic pop, logic przer,
                               logic [7:0] exp_pc, logic [3:0] exp_cnt, logic exp_blad);
      vec_t v;
      v.en = en; v.id_rst = id_rst; v.skok = skok; v.adres = adres;
      v.skok_pc = skok_pc; v.push = push; v.pop = pop; v.przer = przer;
      v.exp_pc = exp_pc; v.exp_cnt = exp_cnt; v.exp_blad = exp_blad;
      return v;
   endfunction

   task automatic check(string name, logic [7:0] exp_pc, logic [3:0] exp_cnt, logic exp_blad);
      checks++;
      if (bus.pc !== exp_pc || bus.stos_pc_ile !== exp_cnt
          || bus.stos_pc_empty !== (exp_cnt == 4'd0) || bus.stos_pc_full !== (exp_cnt == 4'd8)) begin
         errors++;
         $display("FAIL %s: pc=%h cnt=%0d empty=%b full=%b, expected pc=%h cnt=%0d empty=%b full=%b",
                  name, bus.pc, bus.stos_pc_ile, bus.stos_pc_empty, bus.stos_pc_full,
                  exp_pc, exp_cnt, exp_cnt == 4'd0, exp_cnt == 4'd8);
      end
`ifdef PC_STOS_BLAD_EN
      checks++;
      if (bus.stos_pc_blad !== exp_blad) begin
         errors++;
         $display("FAIL %s blad: got %b expected %b", name, bus.stos_pc_blad, exp_blad);
      end
`else
      if (exp_blad === 1'bx) $display("unexpected x in expected blad for %s", name);
`endif
   endtask

   task automatic drive(vec_t v);
      bus.en = v.en; bus.ID_rst = v.id_rst; bus.skok = v.skok; bus.adres_skok = v.adres;
      bus.skok_pc = v.skok_pc; bus.push_pc = v.push; bus.pop_pc = v.pop;
      bus.jest_przerwanie = v.przer;
   endtask

   initial begin
      //          en id sk adres  spc pu po pz  pc     cnt blad
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h01, 0, 0)); // idle
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h02, 0, 0));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h03, 0, 0));
      vecs.push_back(mk(1, 0, 1, 8'h10, 0, 0, 0, 0, 8'h10, 0, 0)); // JMP 0x10
      vecs.push_back(mk(1, 0, 1, 8'h40, 0, 1, 0, 0, 8'h40, 1, 0)); // CALL 0x40
      vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 1, 0, 8'h11, 0, 0)); // RET
      vecs.push_back(mk(1, 0, 1, 8'h22, 0, 0, 0, 0, 8'h22, 0, 0)); // JMP 0x22
      vecs.push_back(mk(1, 0, 1, 8'h08, 0, 1, 0, 1, 8'h08, 1, 0)); // interrupt entry
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h09, 1, 0));
      vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 1, 0, 8'h22, 0, 0)); // RETI
      vecs.push_back(mk(1, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0)); // JMP 0x00
      for (int i = 1; i <= 8; i++)                                   // 8 CALLs
         vecs.push_back(mk(1, 0, 1, 8'h50, 0, 1, 0, 0, 8'h50, 4'(i), 0));
      vecs.push_back(mk(1, 0, 1, 8'h50, 0, 1, 0, 0, 8'h50, 8, 1)); // 9th CALL dropped
      vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 1, 0, 8'h51, 7, 1)); // RET
      for (int i = 0; i < 4; i++)                                    // stall
         vecs.push_back(mk(0, 0, 1, 8'h33, 0, 0, 0, 0, 8'h51, 7, 1));
      vecs.push_back(mk(0, 1, 1, 8'h33, 0, 0, 0, 0, 8'h00, 0, 0)); // ID_rst during stall
      vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 1, 0, 8'h01, 0, 1)); // RET on empty
      vecs.push_back(mk(1, 0, 1, 8'h77, 0, 1, 1, 0, 8'h02, 0, 1)); // push+pop illegal
      vecs.push_back(mk(1, 0, 1, 8'hFF, 0, 0, 0, 0, 8'hFF, 0, 1)); // JMP 0xFF
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1)); // wrap
      vecs.push_back(mk(1, 0, 1, 8'hFF, 0, 0, 0, 0, 8'hFF, 0, 1)); // JMP 0xFF
      vecs.push_back(mk(1, 0, 1, 8'h10, 0, 1, 0, 0, 8'h10, 1, 1)); // CALL pushes 0x00
      vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1)); // RET -> 0x00
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h01, 0, 1)); // bare pop, empty
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h02, 1, 1)); // bare push of 0x02
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h03, 1, 1));
      vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 1, 0, 8'h02, 0, 1)); // RET -> 0x02
      vecs.push_back(mk(1, 1, 1, 8'h40, 0, 1, 0, 0, 8'h00, 0, 0)); // ID_rst beats CALL
      vecs.push_back(mk(1, 0, 1, 8'h30, 0, 0, 0, 0, 8'h30, 0, 0)); // JMP 0x30

      drive(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
      #2;
      check("reset", 8'h00, 4'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt, vecs[i].exp_blad);
         @(negedge clk);
      end

      // CALL in flight, async reset asserted mid-cycle
      drive(mk(1, 0, 1, 8'h60, 0, 1, 0, 0, 8'h00, 0, 0));
      @(posedge clk);
      #1;
      check("call_before_rst", 8'h60, 4'd1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", 8'h00, 4'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      drive(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
      @(posedge clk);
      #1;
      check("after_rst", 8'h01, 4'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end
endmodule
